l1_read_seq: RTL and testbench

L1_READ_SEQ -- requirements
Module: l1_read_seq

---
 rtl/l1_pkg.sv | 34 +++
 rtl/l1_read_seq.sv | 128 ++++++++++++
 tb/tb_l1_read_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/l1_pkg.sv
// -----------------------------------------------------------------------------
// l1_pkg
// Shared definitions for the L1 line-read sequencer.
//   state_e    : sequencer FSM state (IDLE / BURST)
//   l1_req_t   : field packing of the request word i_d = {line, start_beat, len_m1}
//   l1_addr_t  : field packing of the read address o_d = {line, beat}
// The packed structs are sized for the default geometry (WAYS=8,
// RAM_DEPTH=512); the sequencer itself slices i_d/o_d by its own parameters
// so other geometries remain usable.
// -----------------------------------------------------------------------------
package l1_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned L1_WAYS       = 8;
  localparam int unsigned L1_RAM_DEPTH  = 512;
  localparam int unsigned L1_WAYS_WIDTH = $clog2(L1_WAYS);
  localparam int unsigned L1_LINE_WIDTH = $clog2(L1_RAM_DEPTH) - 1;

  typedef struct packed {
    logic [L1_LINE_WIDTH-1:0] line;
    logic [L1_WAYS_WIDTH-1:0] start_beat;
    logic [L1_WAYS_WIDTH-1:0] len_m1;
  } l1_req_t;

  typedef struct packed {
    logic [L1_LINE_WIDTH-1:0] line;
    logic [L1_WAYS_WIDTH-1:0] beat;
  } l1_addr_t;

endpackage

// File: rtl/l1_read_seq.sv
// -----------------------------------------------------------------------------
// l1_read_seq
// Expands a cache-line read request into a sequence of per-beat BRAM read
// addresses, critical beat first, wrapping within the line.
//
// Ports
//   clk1x   in   single clock, rising edge
//   reset   in   synchronous, active-low reset
//   i_v     in   request valid
//   i_r     out  request ready
//   i_d     in   request {line, start_beat, len_m1}
//   o_v     out  read-address valid (registered)
//   o_r     in   read-address ready from the BRAM read stage
//   o_d     out  read address {line, beat} (registered)
//   o_last  out  final beat of the current request, qualified by o_v
// -----------------------------------------------------------------------------
module l1_read_seq
  import l1_pkg::*;
#(
  parameter  int WAYS       = 8,
  parameter  int RAM_DEPTH  = 512,
  localparam int WAYS_WIDTH = $clog2(WAYS),
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
  localparam int LINE_WIDTH = ADDR_WIDTH - 1
) (
  input  logic                             clk1x,
  input  logic                             reset,
  input  logic                             i_v,
  output logic                             i_r,
  input  logic [LINE_WIDTH+2*WAYS_WIDTH-1:0] i_d,
  output logic                             o_v,
  input  logic                             o_r,
  output logic [LINE_WIDTH+WAYS_WIDTH-1:0] o_d,
  output logic                             o_last
);

  // Request fields
  logic [LINE_WIDTH-1:0] req_line_s;
  logic [WAYS_WIDTH-1:0] req_start_s;
  logic [WAYS_WIDTH-1:0] req_len_m1_s;

  // Handshake qualifiers
  logic out_hs_s;
  logic i_r_s;
  logic accept_s;

  // Sequencer state and output registers
  state_e                state_r;
  logic [LINE_WIDTH-1:0] line_r;
  logic [WAYS_WIDTH-1:0] beat_r;
  logic [WAYS_WIDTH-1:0] rem_r;
  logic                  o_v_r;
  logic                  o_last_r;

  assign req_line_s   = i_d[LINE_WIDTH+2*WAYS_WIDTH-1 : 2*WAYS_WIDTH];
  assign req_start_s  = i_d[2*WAYS_WIDTH-1 : WAYS_WIDTH];
  assign req_len_m1_s = i_d[WAYS_WIDTH-1 : 0];

  // Handshake decode. Ready is also raised while the last beat is being
  // taken so a queued request loads into the output register in the same
  // edge and the address stream has no bubble between requests.
  always_comb begin
    out_hs_s = o_v_r & o_r;
    i_r_s    = (state_r == ST_IDLE) | (out_hs_s & o_last_r);
    accept_s = i_v & i_r_s;
  end

  assign i_r    = i_r_s;
  assign o_v    = o_v_r;
  assign o_d    = {line_r, beat_r};
  assign o_last = o_last_r;

  // Sequencer FSM with registered address/valid/last outputs.
  always_ff @(posedge clk1x) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      line_r   <= '0;
      beat_r   <= '0;
      rem_r    <= '0;
      o_v_r    <= 1'b0;
      o_last_r <= 1'b0;
    end else if (accept_s) begin
      // New request: first beat is presented the following cycle. The line
      // is latched once and held for every beat of the request.
      state_r  <= ST_BURST;
      line_r   <= req_line_s;
      beat_r   <= req_start_s;
      rem_r    <= req_len_m1_s;
      o_v_r    <= 1'b1;
      o_last_r <= (req_len_m1_s == WAYS_WIDTH'(0));
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r  <= ST_IDLE;
          o_v_r    <= 1'b0;
          o_last_r <= 1'b0;
        end
        ST_BURST: begin
          if (out_hs_s) begin
            if (o_last_r) begin
              // Last beat taken and nothing queued behind it.
              state_r  <= ST_IDLE;
              o_v_r    <= 1'b0;
              o_last_r <= 1'b0;
            end else begin
              // Beat index wraps by truncation, giving the critical-beat-
              // first order within the line.
              state_r  <= ST_BURST;
              beat_r   <= beat_r + WAYS_WIDTH'(1);
              rem_r    <= rem_r - WAYS_WIDTH'(1);
              o_last_r <= (rem_r == WAYS_WIDTH'(1));
            end
          end else begin
            // Stalled by the read stage: everything holds.
            state_r <= ST_BURST;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          rem_r    <= '0;
          o_v_r    <= 1'b0;
          o_last_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_read_seq.sv
module tb_l1_read_seq;
  import l1_pkg::*;

  localparam int WW = 3;
  localparam int LW = 8;

  logic              clk1x = 1'b0;
  logic              reset;
  logic              i_v;
  logic              i_r;
  logic [LW+2*WW-1:0] i_d;
  logic              o_v;
  logic              o_r;
  logic [LW+WW-1:0]  o_d;
  logic              o_last;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int hs_mark;
  logic [LW+WW:0] exp_q[$];   // {line, beat, last}

  always #5 clk1x = ~clk1x;

  l1_read_seq #(.WAYS(8), .RAM_DEPTH(512)) dut (
    .clk1x (clk1x),
    .reset (reset),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (i_d),
    .o_v   (o_v),
    .o_r   (o_r),
    .o_d   (o_d),
    .o_last(o_last)
  );

  function automatic logic [LW+2*WW-1:0] mk_req(int line, int start, int len_m1);
    l1_req_t r;
    r.line       = LW'(line);
    r.start_beat = WW'(start);
    r.len_m1     = WW'(len_m1);
    return r;
  endfunction

  function automatic logic [LW+WW-1:0] mk_addr(int line, int beat);
    l1_addr_t a;
    a.line = LW'(line);
    a.beat = WW'(beat);
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected beats for one accepted request.
  task automatic push_req(logic [LW+2*WW-1:0] d);
    l1_req_t r;
    logic [WW-1:0] b;
    r = d;
    for (int k = 0; k <= int'(r.len_m1); k++) begin
      b = WW'((int'(r.start_beat) + k) % 8);
      exp_q.push_back({r.line, b, (k == int'(r.len_m1)) ? 1'b1 : 1'b0});
    end
  endtask

  // One clock cycle: called at a negedge with inputs settled; records the
  // accept and output handshakes that the next posedge commits.
  task automatic tick();
    logic [LW+WW:0] e;
    if (reset && i_v && i_r) push_req(i_d);
    if (reset && o_v && o_r) begin
      hs_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", {o_d, o_last});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat", 32'({o_d, o_last}), 32'(e));
      end
    end
    @(posedge clk1x);
    @(negedge clk1x);
  endtask

  task automatic drain(int budget);
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    i_v   = 1'b0;
    i_d   = '0;
    o_r   = 1'b1;
    @(negedge clk1x);
    tick();
    tick();

    // Reset state
    chk("rst_o_v", 32'(o_v), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_d", 32'(o_d), 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_i_r", 32'(i_r), 32'd1);

    // Full line from beat 0, line 5
    i_v = 1'b1;
    i_d = mk_req(5, 0, 7);
    tick();
    i_v = 1'b0;
    i_d = '1;   // ignored while i_v is low
    hs_mark = hs_count;
    for (int k = 0; k < 8; k++) begin
      chk("full_o_v", 32'(o_v), 32'd1);
      tick();
    end
    chk("full_done_o_v", 32'(o_v), 32'd0);
    chk("full_count", 32'(hs_count - hs_mark), 32'd8);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Critical-beat-first wrap: 6,7,0,1
    i_v = 1'b1;
    i_d = mk_req(3, 6, 3);
    tick();
    i_v = 1'b0;
    chk("wrap_first", 32'(o_d), 32'(mk_addr(3, 6)));
    drain(20);
    chk("wrap_done_o_v", 32'(o_v), 32'd0);

    // Single beat
    i_v = 1'b1;
    i_d = mk_req(9, 4, 0);
    tick();
    i_v = 1'b0;
    chk("single_o_d", 32'(o_d), 32'(mk_addr(9, 4)));
    chk("single_o_last", 32'(o_last), 32'd1);
    tick();
    chk("single_done_o_v", 32'(o_v), 32'd0);

    // Back-to-back requests, no bubble
    i_v = 1'b1;
    i_d = mk_req(7, 2, 1);
    tick();
    i_d = mk_req(8, 5, 1);
    chk("b2b_i_r_mid", 32'(i_r), 32'd0);
    chk("b2b_v0", 32'(o_v), 32'd1);
    tick();
    chk("b2b_v1", 32'(o_v), 32'd1);
    chk("b2b_i_r_last", 32'(i_r), 32'd1);
    tick();
    i_v = 1'b0;
    chk("b2b_v2", 32'(o_v), 32'd1);
    chk("b2b_second_first", 32'(o_d), 32'(mk_addr(8, 5)));
    tick();
    chk("b2b_v3", 32'(o_v), 32'd1);
    tick();
    chk("b2b_done_o_v", 32'(o_v), 32'd0);
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on beat 2
    i_v = 1'b1;
    i_d = mk_req(4, 0, 5);
    tick();
    i_v = 1'b0;
    tick();
    tick();
    o_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_o_v", 32'(o_v), 32'd1);
      chk("stall_o_d", 32'(o_d), 32'(mk_addr(4, 2)));
      chk("stall_o_last", 32'(o_last), 32'd0);
    end
    o_r = 1'b1;
    tick();
    chk("stall_next", 32'(o_d), 32'(mk_addr(4, 3)));
    drain(20);

    // Reset mid-burst
    i_v = 1'b1;
    i_d = mk_req(6, 0, 7);
    tick();
    i_v = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    chk("abort_o_v", 32'(o_v), 32'd0);
    chk("abort_o_last", 32'(o_last), 32'd0);
    chk("abort_o_d", 32'(o_d), 32'd0);
    reset = 1'b1;
    hs_mark = hs_count;
    tick();
    chk("abort_i_r", 32'(i_r), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("abort_no_stale", 32'(hs_count - hs_mark), 32'd0);
    chk("abort_idle_o_v", 32'(o_v), 32'd0);

    // Full line with random backpressure: each beat exactly once
    i_v = 1'b1;
    i_d = mk_req(200, 3, 7);
    tick();
    i_v = 1'b0;
    hs_mark = hs_count;
    for (int n = 0; n < 80; n++) begin
      if (exp_q.size() == 0) break;
      o_r = 1'($urandom_range(0, 1));
      tick();
    end
    o_r = 1'b1;
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_count", 32'(hs_count - hs_mark), 32'd8);
    tick();
    chk("rand_done_o_v", 32'(o_v), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
